// File: rtl/isp1761_bus_sequencer.sv
// isp1761_bus_sequencer
// Two Avalon-MM slave ports arbitrated round-robin onto one ISP1761
// asynchronous bus cycle (SETUP -> STROBE -> HOLD [-> TURN] -> IDLE).
// Optional feature macro: ISP1761_SEQ_TURNAROUND_EN adds one TURN cycle
// after each completed read before the bus can be granted again.
//
// Handshake: a port request is (read|write); waitrequest is high while the
// request is pending and drops for exactly the one completion cycle (last
// HOLD cycle of that port's transaction); the requester must hold address,
// data and direction stable until it sees waitrequest low.
module isp1761_bus_sequencer #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 1
) (
    input  logic        csi_clk,
    input  logic        rsi_reset,
    input  logic [17:0] avs_m0_address,
    input  logic        avs_m0_read,
    input  logic        avs_m0_write,
    input  logic [31:0] avs_m0_writedata,
    output logic [31:0] avs_m0_readdata,
    output logic        avs_m0_waitrequest,
    input  logic [17:0] avs_m1_address,
    input  logic        avs_m1_read,
    input  logic        avs_m1_write,
    input  logic [31:0] avs_m1_writedata,
    output logic [31:0] avs_m1_readdata,
    output logic        avs_m1_waitrequest,
    output logic        coe_CS_N,
    output logic        coe_RD_N,
    output logic        coe_WR_N,
    output logic [16:0] coe_A,
    inout  wire  [31:0] coe_D,
    output logic [2:0]  fsm_state
);

    // Out-of-range phase lengths are clamped into 1..15 (4-bit counter).
    localparam int S_EFF = (SETUP_CYC  < 1) ? 1 : (SETUP_CYC  > 15) ? 15 : SETUP_CYC;
    localparam int P_EFF = (STROBE_CYC < 1) ? 1 : (STROBE_CYC > 15) ? 15 : STROBE_CYC;
    localparam int H_EFF = (HOLD_CYC   < 1) ? 1 : (HOLD_CYC   > 15) ? 15 : HOLD_CYC;
    localparam logic [3:0] S_LOAD = 4'(S_EFF - 1);
    localparam logic [3:0] P_LOAD = 4'(P_EFF - 1);
    localparam logic [3:0] H_LOAD = 4'(H_EFF - 1);

`ifdef ISP1761_SEQ_TURNAROUND_EN
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, TURN} state_t;
`else
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD} state_t;
`endif

    state_t      state;
    logic [3:0]  cnt;
    logic        gnt;        // port owning the current transaction
    logic        last_gnt;   // port granted most recently (round-robin pointer)
    logic        is_rd;
    logic        d_oe;
    logic [31:0] wdata_q;
    logic [31:0] cap_q;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;

    logic        req0;
    logic        req1;
    logic        pick;
    logic        sel_rd;
    logic [17:0] sel_addr;
    logic [31:0] sel_wd;
    logic        done;
    logic        addr_lsb_unused;

    assign req0 = avs_m0_read | avs_m0_write;
    assign req1 = avs_m1_read | avs_m1_write;
    assign addr_lsb_unused = sel_addr[0];

    // Round-robin choice: on a tie the port not granted last wins.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) pick = ~last_gnt;
        else if (req1)    pick = 1'b1;
        sel_rd   = pick ? avs_m1_read      : avs_m0_read;
        sel_addr = pick ? avs_m1_address   : avs_m0_address;
        sel_wd   = pick ? avs_m1_writedata : avs_m0_writedata;
    end

    // Completion cycle: last HOLD cycle, never while reset is asserted.
    assign done = !rsi_reset && (state == HOLD) && (cnt == 4'd0);

    assign avs_m0_waitrequest = req0 & ~(done & ~gnt);
    assign avs_m1_waitrequest = req1 & ~(done &  gnt);

    assign avs_m0_readdata = rsi_reset ? 32'd0 :
                             (done && !gnt && is_rd && req0) ? cap_q : rdata0_q;
    assign avs_m1_readdata = rsi_reset ? 32'd0 :
                             (done &&  gnt && is_rd && req1) ? cap_q : rdata1_q;

    assign coe_D     = d_oe ? wdata_q : 32'bz;
    assign fsm_state = state;

    // Bus-cycle sequencer with registered strobes, address and data enable.
    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            is_rd    <= 1'b0;
            d_oe     <= 1'b0;
            wdata_q  <= 32'd0;
            cap_q    <= 32'd0;
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
            coe_CS_N <= 1'b1;
            coe_RD_N <= 1'b1;
            coe_WR_N <= 1'b1;
            coe_A    <= 17'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt      <= pick;
                        last_gnt <= pick;
                        is_rd    <= sel_rd;
                        coe_A    <= sel_addr[17:1];
                        wdata_q  <= sel_wd;
                        d_oe     <= ~sel_rd;
                        coe_CS_N <= 1'b0;
                        cnt      <= S_LOAD;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == 4'd0) begin
                        coe_RD_N <= ~is_rd;
                        coe_WR_N <= is_rd;
                        cnt      <= P_LOAD;
                        state    <= STROBE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                STROBE: begin
                    if (cnt == 4'd0) begin
                        if (is_rd) cap_q <= coe_D;
                        coe_RD_N <= 1'b1;
                        coe_WR_N <= 1'b1;
                        cnt      <= H_LOAD;
                        state    <= HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 4'd0) begin
                        coe_CS_N <= 1'b1;
                        d_oe     <= 1'b0;
                        // A withdrawn requester gets no data back.
                        if (is_rd && !gnt && req0) rdata0_q <= cap_q;
                        if (is_rd &&  gnt && req1) rdata1_q <= cap_q;
`ifdef ISP1761_SEQ_TURNAROUND_EN
                        state <= is_rd ? TURN : IDLE;
`else
                        state <= IDLE;
`endif
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
`ifdef ISP1761_SEQ_TURNAROUND_EN
                TURN: state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
